instruction_fetch: RTL and testbench

Fetch stage directly downstream of the instruction memory. Owns the program counter and drives it as the memory address. Takes the 32-bit, halfword-aligned window returned combinationally by the memory. Splits it into 16-bit compressed or 32-bit full instructions and presents one instruction per cycle to decode through a valid/ready handshake, with redirect (branch/jump) and halt support.

---
 rtl/instruction_fetch.sv | 139 +++++++++++++
 tb/tb_instruction_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, splits the 32-bit memory window into 16/32-bit
// instructions and hands one per cycle to decode over a valid/ready register.
module instruction_fetch #(
  parameter int                  PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  output logic [PC_WIDTH-1:0]   imem_address,
  input  logic [DATA_WIDTH-1:0] imem_read_data,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic                  out_compressed,
  output logic                  out_fault
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [PC_WIDTH-1:0]   out_pc_q, out_pc_d;
  logic                  out_compressed_q, out_compressed_d;
  logic                  out_fault_q, out_fault_d;

  logic can_load;
  logic rd_compressed;
  logic rd_illegal;

  assign imem_address   = pc_q;
  assign out_valid      = out_valid_q;
  assign out_instr      = out_instr_q;
  assign out_pc         = out_pc_q;
  assign out_compressed = out_compressed_q;
  assign out_fault      = out_fault_q;

  // Next-state logic: redirect beats capture, capture beats drain/stall.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    out_valid_d      = out_valid_q;
    out_instr_d      = out_instr_q;
    out_pc_d         = out_pc_q;
    out_compressed_d = out_compressed_q;
    out_fault_d      = out_fault_q;
    can_load         = !out_valid_q || out_ready;
    rd_compressed    = (imem_read_data[1:0] != 2'b11);
    rd_illegal       = (imem_read_data[15:0] == 16'h0000);

    if (redirect_valid) begin
      if (redirect_pc[0]) begin
        // Odd target: report it as a fault entry instead of fetching.
        out_valid_d      = 1'b1;
        out_fault_d      = 1'b1;
        out_pc_d         = redirect_pc;
        out_instr_d      = '0;
        out_compressed_d = 1'b0;
        state_d          = ST_TRAP;
      end else begin
        out_valid_d = 1'b0;
        pc_d        = redirect_pc;
        state_d     = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (fetch_en && can_load) begin
            out_valid_d      = 1'b1;
            out_pc_d         = pc_q;
            out_compressed_d = rd_compressed;
            if (rd_compressed) begin
              out_instr_d = {{(DATA_WIDTH-16){1'b0}}, imem_read_data[15:0]};
            end else begin
              out_instr_d = imem_read_data;
            end
            if (rd_illegal) begin
              out_fault_d = 1'b1;
              state_d     = ST_TRAP;
            end else begin
              out_fault_d = 1'b0;
              if (rd_compressed) begin
                pc_d = pc_q + PC_WIDTH'(2);
              end else begin
                pc_d = pc_q + PC_WIDTH'(4);
              end
            end
          end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = out_valid_q;
          end
        end
        ST_TRAP: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = out_valid_q;
          end
        end
        default: begin
          out_valid_d = 1'b0;
          state_d     = ST_TRAP;
        end
      endcase
    end
  end

  // State, PC and output register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_RUN;
      pc_q             <= RESET_PC;
      out_valid_q      <= 1'b0;
      out_instr_q      <= '0;
      out_pc_q         <= '0;
      out_compressed_q <= 1'b0;
      out_fault_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      out_valid_q      <= out_valid_d;
      out_instr_q      <= out_instr_d;
      out_pc_q         <= out_pc_d;
      out_compressed_q <= out_compressed_d;
      out_fault_q      <= out_fault_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed vectors push expected
// entries, a negedge monitor pops and compares on every accepted output.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [15:0] imem_address;
  logic [31:0] imem_read_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        out_compressed;
  logic        out_fault;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] pc;
    logic        comp;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] mem [0:32767];

  instruction_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_address   (imem_address),
    .imem_read_data (imem_read_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_compressed (out_compressed),
    .out_fault      (out_fault)
  );

  always #5 clk = ~clk;

  // Combinational memory: {parcel@PC+2, parcel@PC}, addresses wrap at 16 bits.
  always_comb begin
    logic [15:0] a2;
    a2 = imem_address + 16'd2;
    imem_read_data = {mem[a2[15:1]], mem[imem_address[15:1]]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [15:0] pc,
                      input logic comp, input logic fault);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.comp  = comp;
    e.fault = fault;
    sb.push_back(e);
  endtask

  task automatic wr32(input logic [15:0] a, input logic [31:0] d);
    logic [15:0] a2;
    a2 = a + 16'd2;
    mem[a[15:1]]  = d[15:0];
    mem[a2[15:1]] = d[31:16];
  endtask

  // Monitor: every accepted entry must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !redirect_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got instr=0x%0h pc=0x%0h, expected none", out_instr, out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_instr !== e.instr || out_pc !== e.pc ||
            out_compressed !== e.comp || out_fault !== e.fault) begin
          n_err++;
          $display("FAIL sb_entry: got instr=0x%0h pc=0x%0h c=%0b f=%0b expected instr=0x%0h pc=0x%0h c=%0b f=%0b",
                   out_instr, out_pc, out_compressed, out_fault, e.instr, e.pc, e.comp, e.fault);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0001;
    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;

    // Reset state and basic 32/16 stream
    wr32(16'h0000, 32'h00A00093);
    mem[2] = 16'h4505;
    step(); step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_addr", {16'd0, imem_address}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", {16'd0, out_pc}, 32'd0);
    rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    push(32'h00A00093, 16'h0000, 1'b0, 1'b0);
    push(32'h00004505, 16'h0004, 1'b1, 1'b0);
    check("t1_addr0", {16'd0, imem_address}, 32'h0);
    step();
    check("t1_addr4", {16'd0, imem_address}, 32'h4);
    step();
    check("t1_addr6", {16'd0, imem_address}, 32'h6);
    fetch_en = 1'b0;
    step();
    check("t1_drain", {31'd0, out_valid}, 32'd0);

    // Mixed 16/32/16 with a 3-cycle stall
    rst_n = 1'b0; step(); rst_n = 1'b1;
    mem[0] = 16'h4501;
    wr32(16'h0002, 32'h00B00113);
    mem[3] = 16'h4609;
    push(32'h00004501, 16'h0000, 1'b1, 1'b0);
    push(32'h00B00113, 16'h0002, 1'b0, 1'b0);
    push(32'h00004609, 16'h0006, 1'b1, 1'b0);
    fetch_en = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_stall_pc", {16'd0, out_pc}, 32'h0);
      check("t2_stall_addr", {16'd0, imem_address}, 32'h2);
      check("t2_stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step(); step();
    fetch_en = 1'b0;
    check("t2_addr8", {16'd0, imem_address}, 32'h8);
    step();

    // Redirect over an unaccepted entry
    mem[8] = 16'h4701;
    fetch_en = 1'b1; out_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    step();
    check("t3_flush_valid", {31'd0, out_valid}, 32'd0);
    check("t3_redir_addr", {16'd0, imem_address}, 32'h10);
    redirect_valid = 1'b0; out_ready = 1'b1;
    push(32'h00004701, 16'h0010, 1'b1, 1'b0);
    step();
    check("t3_out_pc", {16'd0, out_pc}, 32'h10);
    fetch_en = 1'b0;
    step();

    // Misaligned redirect, then recover with aligned redirect
    fetch_en = 1'b1; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 16'h0011;
    step();
    check("t4_fault_valid", {31'd0, out_valid}, 32'd1);
    check("t4_fault", {31'd0, out_fault}, 32'd1);
    check("t4_fault_pc", {16'd0, out_pc}, 32'h11);
    check("t4_fault_instr", out_instr, 32'd0);
    redirect_valid = 1'b0; out_ready = 1'b1;
    push(32'h00000000, 16'h0011, 1'b0, 1'b1);
    step();
    check("t4_trap_drop", {31'd0, out_valid}, 32'd0);
    check("t4_trap_addr", {16'd0, imem_address}, 32'h12);
    step();
    check("t4_trap_nofetch", {31'd0, out_valid}, 32'd0);
    mem[16] = 16'h4801;
    redirect_valid = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect_valid = 1'b0;
    push(32'h00004801, 16'h0020, 1'b1, 1'b0);
    step();
    check("t4_out_pc20", {16'd0, out_pc}, 32'h20);
    fetch_en = 1'b0;
    step();

    // Illegal all-zero parcel at 8
    mem[4] = 16'h0000;
    redirect_valid = 1'b1; redirect_pc = 16'h0008;
    step();
    redirect_valid = 1'b0; fetch_en = 1'b1;
    push(32'h00000000, 16'h0008, 1'b1, 1'b1);
    step();
    check("t5_fault", {31'd0, out_fault}, 32'd1);
    check("t5_pc", {16'd0, out_pc}, 32'h8);
    check("t5_addr", {16'd0, imem_address}, 32'h8);
    step();
    check("t5_trap_addr", {16'd0, imem_address}, 32'h8);
    check("t5_trap_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream with a held entry
    fetch_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 16'h0030;
    step();
    redirect_valid = 1'b0; fetch_en = 1'b1; out_ready = 1'b0;
    step();
    check("t6_held_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_addr", {16'd0, imem_address}, 32'h0);
    rst_n = 1'b1; fetch_en = 1'b0;

    // PC wrap from 0xFFFC
    wr32(16'hFFFC, 32'h00500513);
    redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
    step();
    redirect_valid = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    push(32'h00500513, 16'hFFFC, 1'b0, 1'b0);
    step();
    check("t7_wrap_addr", {16'd0, imem_address}, 32'h0);
    check("t7_wrap_pc", {16'd0, out_pc}, 32'hFFFC);
    fetch_en = 1'b0;
    step(); step();

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
